// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 INCR burst initiator
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WDATA_S, WRESP, RADDR, RDATA_S, DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [8:0]            beat_cnt;
  logic [1:0]            status;

  // End offset of the burst within its 4 KB page; anything past 4096 crosses it.
  logic [13:0] end_off;
  logic        cmd_illegal;
  logic        cmd_fire;
  logic        at_end;
  logic        w_hs;
  logic        r_hs;
  logic [1:0]  rresp_max;

  assign end_off     = {2'b00, cmd_addr[11:0]} + {4'b0000, cmd_len, 2'b00} + 14'd4;
  assign cmd_illegal = (cmd_addr[1:0] != 2'b00) || (end_off > 14'd4096);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign at_end      = (beat_cnt == {1'b0, len_q});
  assign w_hs        = (state == WDATA_S) && wr_valid && WREADY;
  assign r_hs        = (state == RDATA_S) && RVALID && rd_ready;
  assign rresp_max   = (RRESP > status) ? RRESP : status;

  assign AWADDR = addr_q;
  assign AWLEN  = len_q;
  assign AWSIZE = 3'b010;
  assign ARADDR = addr_q;
  assign ARLEN  = len_q;
  assign ARSIZE = 3'b010;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    AWVALID    = 1'b0;
    ARVALID    = 1'b0;
    WVALID     = 1'b0;
    WDATA      = '0;
    WLAST      = 1'b0;
    wr_ready   = 1'b0;
    BREADY     = 1'b0;
    RREADY     = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    done       = 1'b0;
    done_resp  = 2'b00;
    case (state)
      IDLE: begin
        // Held low while reset is asserted so nothing is accepted into a resetting block.
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET) begin
          if (cmd_illegal)    state_next = DONE;
          else if (cmd_write) state_next = WADDR;
          else                state_next = RADDR;
        end
      end
      WADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_next = WDATA_S;
      end
      WDATA_S: begin
        WVALID   = wr_valid;
        WDATA    = wr_data;
        wr_ready = WREADY;
        WLAST    = at_end;
        if (w_hs && at_end) state_next = WRESP;
      end
      WRESP: begin
        BREADY = 1'b1;
        if (BVALID) state_next = DONE;
      end
      RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_next = RDATA_S;
      end
      RDATA_S: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = RLAST;
        if (r_hs && (at_end || RLAST)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        done_resp  = status;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      status   <= 2'b00;
    end else begin
      if (state == IDLE && cmd_fire) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        beat_cnt <= '0;
        status   <= cmd_illegal ? 2'b10 : 2'b00;
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
      if (state == WRESP && BVALID) begin
        status <= BRESP;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        // A misplaced or missing RLAST always ends the burst, so forcing here is final.
        status <= (RLAST != at_end) ? 2'b10 : rresp_max;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - scoreboard bench for axi4_burst_master
module tb_axi4_burst_master;

  logic        ACLK, ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  int total = 0;
  int bad   = 0;

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
    ARREADY = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
  endtask

  // Issue a command at the next negedge; returns at the negedge after the accept edge.
  task automatic issue_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len, input string tag);
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s_cmd_ready got=%b want=1", tag, cmd_ready);
    end
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 0;
  endtask

  task automatic run_write(input logic [15:0] addr, input logic [7:0] len, input int aw_delay,
                           input bit bp, input logic [1:0] bresp, input int abort_after,
                           input int exp_done_cyc, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] src[$];
    logic [31:0] e;
    int  t, nbeats;
    bit  aw_done, aw_hs, consumed, fin;
    for (int i = 0; i <= int'(len); i++) begin
      src.push_back(32'hA0 + i);
      exp_q.push_back(32'hA0 + i);
    end
    issue_cmd(1'b1, addr, len, tag);
    t = 1; nbeats = 0; aw_done = 0; consumed = 0; fin = 0;
    while (!fin && t < 300) begin
      if (abort_after >= 0 && nbeats == abort_after) return;
      if (consumed) begin wr_valid = 0; consumed = 0; end
      AWREADY = (t > aw_delay);
      WREADY  = bp ? t[0] : 1'b1;
      if (src.size() > 0) begin
        if (!wr_valid) wr_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        wr_data = src[0];
      end else begin
        wr_valid = 0;
      end
      BVALID = 1; BRESP = bresp;
      #1;
      aw_hs = 0;
      if (AWVALID) begin
        total++;
        if (AWADDR !== addr || AWLEN !== len || AWSIZE !== 3'b010) begin
          bad++; $display("FAIL %s_aw got=%h/%0d/%0d want=%h/%0d/2", tag, AWADDR, AWLEN, AWSIZE, addr, len);
        end
        aw_hs = AWREADY;
      end
      if (!aw_done) begin
        total++;
        if (WVALID !== 1'b0) begin bad++; $display("FAIL %s_w_before_aw got=%b want=0", tag, WVALID); end
      end else if (nbeats <= int'(len)) begin
        total++;
        if (WVALID !== wr_valid) begin bad++; $display("FAIL %s_wvalid got=%b want=%b", tag, WVALID, wr_valid); end
      end
      if (nbeats <= int'(len)) begin
        total++;
        if (BREADY !== 1'b0) begin bad++; $display("FAIL %s_bready_early got=%b want=0", tag, BREADY); end
      end
      if (WVALID && WREADY) begin
        e = exp_q.pop_front();
        total++;
        if (WDATA !== e) begin bad++; $display("FAIL %s_wdata got=%h want=%h", tag, WDATA, e); end
        total++;
        if (WLAST !== (exp_q.size() == 0)) begin
          bad++; $display("FAIL %s_wlast got=%b want=%b", tag, WLAST, exp_q.size() == 0);
        end
        void'(src.pop_front());
        nbeats++;
        consumed = 1;
      end
      if (done) begin
        fin = 1;
        total++;
        if (done_resp !== bresp) begin bad++; $display("FAIL %s_done_resp got=%b want=%b", tag, done_resp, bresp); end
        total++;
        if (nbeats != int'(len) + 1) begin bad++; $display("FAIL %s_beats got=%0d want=%0d", tag, nbeats, int'(len) + 1); end
        if (exp_done_cyc > 0) begin
          total++;
          if (t != exp_done_cyc) begin bad++; $display("FAIL %s_done_cycle got=%0d want=%0d", tag, t, exp_done_cyc); end
        end
      end
      @(posedge ACLK);
      if (aw_hs) aw_done = 1;
      t++;
      @(negedge ACLK);
    end
    total++;
    if (!fin) begin bad++; $display("FAIL %s_timeout got=no_done want=done", tag); end
    idle_inputs();
    #1;
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s_after_done got=done%b/ready%b want=done0/ready1", tag, done, cmd_ready);
    end
  endtask

  task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input int last_beat,
                          input int err_beat, input logic [31:0] base, input logic [1:0] exp_resp,
                          input string tag);
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [31:0] ed;
    logic        el;
    int  t, beat, last_hs, exp_beats;
    bit  ar_done, ar_hs, pushed, ended, fin;
    exp_beats = ((last_beat < int'(len)) ? last_beat : int'(len)) + 1;
    issue_cmd(1'b0, addr, len, tag);
    t = 1; beat = 0; last_hs = -10; ar_done = 0; pushed = 0; ended = 0; fin = 0;
    while (!fin && t < 300) begin
      ARREADY = 1; rd_ready = 1;
      if (ar_done && !ended) begin
        RVALID = 1; RDATA = base + beat; RLAST = (beat == last_beat);
        RRESP = (beat == err_beat) ? 2'b10 : 2'b00;
        if (!pushed) begin exp_d.push_back(RDATA); exp_l.push_back(RLAST); pushed = 1; end
      end else begin
        RVALID = 0; RLAST = 0; RRESP = 0;
      end
      #1;
      ar_hs = 0;
      if (ARVALID) begin
        total++;
        if (ARADDR !== addr || ARLEN !== len || ARSIZE !== 3'b010 || RREADY !== 1'b0) begin
          bad++; $display("FAIL %s_ar got=%h/%0d/%0d/rr%b want=%h/%0d/2/rr0", tag, ARADDR, ARLEN, ARSIZE, RREADY, addr, len);
        end
        ar_hs = ARREADY;
      end
      if (rd_valid && rd_ready) begin
        ed = exp_d.pop_front(); el = exp_l.pop_front();
        total++;
        if (rd_data !== ed || rd_last !== el) begin
          bad++; $display("FAIL %s_rbeat got=%h/%b want=%h/%b", tag, rd_data, rd_last, ed, el);
        end
        if (RLAST || beat == int'(len)) ended = 1;
        beat++; pushed = 0; last_hs = t;
      end
      if (done) begin
        fin = 1;
        total++;
        if (done_resp !== exp_resp) begin bad++; $display("FAIL %s_done_resp got=%b want=%b", tag, done_resp, exp_resp); end
        total++;
        if (beat != exp_beats) begin bad++; $display("FAIL %s_beats got=%0d want=%0d", tag, beat, exp_beats); end
        total++;
        if (t != last_hs + 1) begin bad++; $display("FAIL %s_done_lat got=%0d want=%0d", tag, t, last_hs + 1); end
      end
      @(posedge ACLK);
      if (ar_hs) ar_done = 1;
      t++;
      @(negedge ACLK);
    end
    total++;
    if (!fin) begin bad++; $display("FAIL %s_timeout got=no_done want=done", tag); end
    idle_inputs();
    #1;
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s_after_done got=done%b/ready%b want=done0/ready1", tag, done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    total++;
    if (cmd_ready !== 0 || AWVALID !== 0 || ARVALID !== 0 || WVALID !== 0 || WLAST !== 0 ||
        BREADY !== 0 || RREADY !== 0 || wr_ready !== 0 || rd_valid !== 0 || rd_last !== 0 || done !== 0) begin
      bad++; $display("FAIL reset_ctrl got=%b%b%b%b%b%b%b%b%b%b%b want=00000000000", cmd_ready, AWVALID, ARVALID,
                      WVALID, WLAST, BREADY, RREADY, wr_ready, rd_valid, rd_last, done);
    end
    total++;
    if (done_resp !== 0 || AWLEN !== 0 || ARLEN !== 0 || AWADDR !== 0 || ARADDR !== 0 ||
        AWSIZE !== 3'b010 || ARSIZE !== 3'b010) begin
      bad++; $display("FAIL reset_vals got=%b/%0d/%0d/%h/%h/%0d/%0d want=0/0/0/0/0/2/2", done_resp, AWLEN, ARLEN,
                      AWADDR, ARADDR, AWSIZE, ARSIZE);
    end
    ARESET = 0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    run_write(16'h0010, 8'd3, 0, 0, 2'b00, -1, 7, "wr_basic");
  endtask

  task automatic test_read_basic();
    run_read(16'h0100, 8'd0, 0, -1, 32'hDEADBEEF, 2'b00, "rd_basic");
  endtask

  task automatic test_backpressure();
    run_write(16'h0040, 8'd7, 3, 1, 2'b00, -1, 0, "wr_bp");
  endtask

  task automatic test_illegal();
    logic [15:0] addrs[3];
    logic [7:0]  lens[3];
    addrs[0] = 16'h0FF8; lens[0] = 8'd3;
    addrs[1] = 16'h0002; lens[1] = 8'd0;
    addrs[2] = 16'h1F00; lens[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      issue_cmd(i[0], addrs[i], lens[i], "illegal");
      #1;
      total++;
      if (done !== 1'b1 || done_resp !== 2'b10 || AWVALID !== 1'b0 || ARVALID !== 1'b0) begin
        bad++; $display("FAIL illegal_%0d got=d%b/r%b/aw%b/ar%b want=d1/r10/aw0/ar0", i, done, done_resp, AWVALID, ARVALID);
      end
      @(negedge ACLK);
      #1;
      total++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL illegal_%0d_after got=d%b/rdy%b want=d0/rdy1", i, done, cmd_ready);
      end
    end
    run_write(16'h0FF0, 8'd3, 0, 0, 2'b01, -1, 7, "wr_page_edge");
  endtask

  task automatic test_read_errors();
    run_read(16'h0200, 8'd3, 2, -1, 32'h1000_0000, 2'b10, "rd_early_last");
    run_read(16'h0300, 8'd3, 3, 1, 32'h2000_0000, 2'b10, "rd_slverr");
    run_read(16'h0400, 8'd2, 5, -1, 32'h3000_0000, 2'b10, "rd_missing_last");
  endtask

  task automatic test_reset_midburst();
    run_write(16'h0500, 8'd7, 0, 0, 2'b00, 2, 0, "wr_abort");
    ARESET = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    #1;
    total++;
    if (AWVALID !== 0 || WVALID !== 0 || WLAST !== 0 || wr_ready !== 0 || BREADY !== 0 || done !== 0 || cmd_ready !== 0) begin
      bad++; $display("FAIL midreset_outs got=%b%b%b%b%b%b%b want=0000000", AWVALID, WVALID, WLAST, wr_ready, BREADY, done, cmd_ready);
    end
    ARESET = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL midreset_idle_%0d got=d%b/rdy%b want=d0/rdy1", i, done, cmd_ready);
      end
      @(negedge ACLK);
    end
    run_read(16'h0600, 8'd1, 1, -1, 32'h4000_0000, 2'b00, "rd_after_reset");
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_backpressure();
    test_illegal();
    test_read_errors();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

Bus initiator for the AXI4 memory-mapped slave. It accepts single burst commands (read or write, start address, length) from a local command port, runs the matching AXI4 INCR burst on the AW/W/B or AR/R channels, and returns one completion status per command. It sits between test or control logic and the slave's AXI4 port, and is the bench's and system's way of driving bursts into the slave.

## Interface
- DATA_WIDTH, 32, data bus width; fixed 4-byte beats.
- ADDR_WIDTH, 16, byte address width.
- ACLK  input  1  clock; all logic on rising edge.
- ARESET  input  1  reset, synchronous, active-high.
- cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_WIDTH  start byte address.
- cmd_len  input  8  beats minus 1 (AXI encoding, 0..255).
- wr_data / wr_valid / wr_ready  input / input / output  DATA_WIDTH / 1 / 1  write-data source stream.
- rd_data / rd_valid / rd_last / rd_ready  output / output / output / input  DATA_WIDTH / 1 / 1 / 1  read-data sink stream.
- done  output  1  one-cycle completion pulse.
- done_resp  output  2  completion status, valid with done.
- AWADDR, AWLEN, AWSIZE, AWVALID  output; AWREADY  input.
- WDATA, WLAST, WVALID  output; WREADY  input.
- BRESP, BVALID  input; BREADY  output.
- ARADDR, ARLEN, ARSIZE, ARVALID  output; ARREADY  input.
- RDATA, RRESP, RLAST, RVALID  input; RREADY  output.

## Operation
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, the block latches addr, len, and write.
  - Illegal command (addr[1:0]!=0, or addr[11:0] + 4*(len+1) > 4096, i.e. crosses a 4 KB boundary): no bus activity, go to DONE with status 2'b10.
  - Legal write: go to WADDR. Legal read: go to RADDR.
- WADDR: AWVALID=1 with AWADDR=addr, AWLEN=len, AWSIZE=3'b010. Outputs are registered and stable until AWREADY. On AWVALID&AWREADY, go to WDATA.
- WDATA: WVALID=wr_valid, WDATA=wr_data, and wr_ready=WREADY (all combinational, gated by state). The 9-bit beat counter increments on WVALID&WREADY. WLAST=(count==len). After the last-beat handshake, go to WRESP.
- WRESP: BREADY=1. On BVALID, status=BRESP, go to DONE.
- RADDR: mirrors WADDR on the AR channel. On ARVALID&ARREADY, go to RDATA.
- RDATA: RREADY=rd_ready. rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST (combinational, gated by state). The beat counter increments on RVALID&RREADY.
  - Status accumulates as the maximum RRESP seen over all beats.
  - A beat with RLAST=1 where count!=len, or RLAST=0 where count==len, forces status 2'b10.
  - Exit to DONE on the beat where count==len or RLAST=1, whichever comes first.
- DONE: done=1 and done_resp=status for exactly one cycle, then go to IDLE. Status clears on the next command accept.
- Only one command is outstanding at a time. AW completes before W starts. No W beat is issued before the AW handshake.

## Timing
- Reset values: cmd_ready=0 while ARESET is high, 1 on the first cycle after release. Every VALID/READY/LAST output, done, and wr_ready/rd_valid are 0. done_resp, AWLEN, and ARLEN are 0. AWADDR and ARADDR are 0. AWSIZE and ARSIZE are 3'b010.
- ARESET asserted mid-burst: at the next edge all outputs return to reset values and the state returns to IDLE. There is no done pulse, and the partial burst is abandoned.
- Command accept at edge N puts AWVALID/ARVALID high from cycle N+1.
- Best-case write, zero wait states, len=L: AW 1 cycle, W L+1 cycles, B 1 cycle, done at cycle N+L+4.
- Best-case read: done one cycle after the final R beat.
- Illegal command: done at cycle N+1.
- VALID outputs never drop before their handshake completes. Address and data stay stable while VALID=1 and READY=0.
- BVALID or RVALID arriving in other states is ignored: B/RREADY is 0 outside WRESP/RDATA.

## Test plan
- Write addr=0x0010, len=3, data 0xA0..0xA3, slave always ready, BRESP=0 -> AWLEN=3, 4 W beats, WLAST only on 0xA3, done at accept+7, done_resp=0.
- Read addr=0x0100, len=0, slave returns 0xDEADBEEF with RLAST, RRESP=0 -> rd_data=0xDEADBEEF, rd_last=1, done_resp=0.
- Backpressure: write len=7 with AWREADY delayed 3 cycles, WREADY toggled every cycle, and wr_valid gaps -> AW and W outputs held stable, exactly 8 beats, WLAST on the 8th.
- Illegal: addr=0x0FF8, len=3 (crosses 4 KB), and separately addr=0x0002 -> no AWVALID, done at accept+1, done_resp=2'b10.
- Read len=3 with RLAST on beat 2, and separately RRESP=2'b10 on beat 1 -> done_resp=2'b10 in both cases, state returns to IDLE.
- ARESET pulsed during beat 2 of a len=7 write -> all VALIDs 0 next cycle, no done, and a following legal read completes normally.
